// File: rtl/dawg_domain_arbiter.sv
// dawg_domain_arbiter: round-robin scheduler sharing one DAWG cacheline among security domains.
// Optional DAWG_ARB_STATS_EN adds saturating hit/miss/switch counters.
module dawg_domain_arbiter #(
   parameter int NUM_DOMAINS = 4,
   parameter int DOM_WIDTH   = 2,
   parameter int NUM_WAYS    = 8,
   parameter int ADDR_WIDTH  = 8,
   parameter int CNT_WIDTH   = 16
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic [NUM_DOMAINS-1:0]            req_valid,
   input  logic [NUM_DOMAINS*ADDR_WIDTH-1:0] req_addr,
   output logic [NUM_DOMAINS-1:0]            req_ready,
   output logic [NUM_DOMAINS-1:0]            rsp_valid,
   output logic                              rsp_hit,
   input  logic                              cfg_we,
   input  logic [DOM_WIDTH-1:0]              cfg_dom,
   input  logic [NUM_WAYS-1:0]               cfg_hitmap,
   output logic                              cfg_ready,
   output logic                              busy,
   output logic                              cl_reset,
   output logic                              cl_os_req,
   output logic [NUM_WAYS-1:0]               cl_hitmap,
   output logic                              cl_user_req,
   output logic [ADDR_WIDTH-1:0]             cl_addr,
   input  logic                              cl_hit
`ifdef DAWG_ARB_STATS_EN
   ,
   output logic [NUM_DOMAINS*CNT_WIDTH-1:0]  stat_hits,
   output logic [NUM_DOMAINS*CNT_WIDTH-1:0]  stat_misses,
   output logic [CNT_WIDTH-1:0]              stat_switches
`endif
);
   typedef enum logic [2:0] {INIT, IDLE, SWITCH, ACCESS, RESP} state_t;
   state_t state, state_nx;
   logic [NUM_WAYS-1:0] hitmap [NUM_DOMAINS];
   logic [DOM_WIDTH-1:0] rr_ptr, dom, loaded_dom, win;
   logic [ADDR_WIDTH-1:0] addr;
   logic loaded_valid, found, accept;
   // first requesting domain at or after rr_ptr, wrapping
   always_comb begin
      found = 1'b0;
      win = '0;
      for (int i = 0; i < NUM_DOMAINS; i++)
         if (!found && req_valid[(int'(rr_ptr) + i) % NUM_DOMAINS]) begin
            found = 1'b1;
            win = DOM_WIDTH'((int'(rr_ptr) + i) % NUM_DOMAINS);
         end
   end
   assign accept = state == IDLE && !cfg_we && found;
   always_comb begin
      state_nx = state;
      state_nx = state == INIT   ? IDLE :
                 state == IDLE   ? (accept ? ((loaded_valid && loaded_dom == win) ? ACCESS : SWITCH) : IDLE) :
                 state == SWITCH ? ACCESS :
                 state == ACCESS ? RESP : IDLE;
   end
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state <= INIT;
         for (int i = 0; i < NUM_DOMAINS; i++) hitmap[i] <= '0;
         loaded_valid <= 1'b0;
         loaded_dom <= '0;
         rr_ptr <= '0;
         dom <= '0;
         addr <= '0;
      end else begin
         state <= state_nx;
         if (state == IDLE && cfg_we) begin
            hitmap[cfg_dom] <= cfg_hitmap;
            if (cfg_dom == loaded_dom) loaded_valid <= 1'b0;
         end
         if (accept) begin
            dom <= win;
            addr <= req_addr[win*ADDR_WIDTH +: ADDR_WIDTH];
            rr_ptr <= DOM_WIDTH'((int'(win) + 1) % NUM_DOMAINS);
         end
         if (state == SWITCH) begin
            loaded_dom <= dom;
            loaded_valid <= 1'b1;
         end
      end
   assign req_ready   = accept ? NUM_DOMAINS'(1) << win : '0;
   assign cfg_ready   = state == IDLE;
   assign busy        = state != IDLE;
   assign cl_reset    = state == INIT;
   assign cl_os_req   = state == SWITCH;
   assign cl_hitmap   = state == SWITCH ? hitmap[dom] : '0;
   assign cl_user_req = state == ACCESS;
   assign cl_addr     = state == ACCESS ? addr : '0;
   assign rsp_valid   = state == RESP ? NUM_DOMAINS'(1) << dom : '0;
   assign rsp_hit     = state == RESP ? cl_hit : 1'b0;
`ifdef DAWG_ARB_STATS_EN
   logic [CNT_WIDTH-1:0] hit_cnt [NUM_DOMAINS];
   logic [CNT_WIDTH-1:0] miss_cnt [NUM_DOMAINS];
   logic [CNT_WIDTH-1:0] sw_cnt;
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         for (int i = 0; i < NUM_DOMAINS; i++) begin
            hit_cnt[i] <= '0;
            miss_cnt[i] <= '0;
         end
         sw_cnt <= '0;
      end else begin
         if (state == SWITCH && sw_cnt != '1) sw_cnt <= sw_cnt + 1'b1;
         if (state == RESP && cl_hit && hit_cnt[dom] != '1) hit_cnt[dom] <= hit_cnt[dom] + 1'b1;
         if (state == RESP && !cl_hit && miss_cnt[dom] != '1) miss_cnt[dom] <= miss_cnt[dom] + 1'b1;
      end
   for (genvar g = 0; g < NUM_DOMAINS; g++) begin : g_stat
      assign stat_hits[g*CNT_WIDTH +: CNT_WIDTH]   = hit_cnt[g];
      assign stat_misses[g*CNT_WIDTH +: CNT_WIDTH] = miss_cnt[g];
   end
   assign stat_switches = sw_cnt;
`endif
endmodule
